// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding load/store responder over a word-organised byte-lane store
//
// Purpose:
//   Accepts one request at a time on a valid/ready request channel, performs a
//   read-before-write access to a word-organised storage array with per-byte
//   active-low write enables, and returns the pre-write word (or an error) on a
//   valid/ready response channel. The request-to-response latency is fixed.
//
// Optional feature macro: MEM_RESPONDER_RANGE_CHK_EN
//   defined   : word index >= DEPTH_WORDS is rejected (rsp_err=1, rsp_rdata=0, no write)
//   undefined : word index wraps modulo DEPTH_WORDS; rsp_err reports misalignment only
//
// Ports:
//   clk           in   clock, all state on rising edge
//   rstL          in   asynchronous active-low reset
//   req_valid     in   request present
//   req_ready     out  responder can accept a request (high only in IDLE)
//   req_addr      in   byte address
//   req_wenableL  in   per-lane write enable, active-low; all ones = pure read
//   req_wdata     in   write data, lane i = bits [8i+7:8i]
//   rsp_valid     out  response present
//   rsp_ready     in   requester accepts response
//   rsp_rdata     out  word contents before any write of this request
//   rsp_err       out  request rejected, storage unchanged

module mem_responder #(
   parameter int ADDR_WIDTH       = 16,
   parameter int DATA_WIDTH_BYTES = 4,
   parameter int DEPTH_WORDS      = 1024
) (
   input  logic                          clk,
   input  logic                          rstL,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [ADDR_WIDTH-1:0]         req_addr,
   input  logic [DATA_WIDTH_BYTES-1:0]   req_wenableL,
   input  logic [8*DATA_WIDTH_BYTES-1:0] req_wdata,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [8*DATA_WIDTH_BYTES-1:0] rsp_rdata,
   output logic                          rsp_err
);

   localparam int LSB  = $clog2(DATA_WIDTH_BYTES);
   localparam int DW   = 8 * DATA_WIDTH_BYTES;
   localparam int IDXW = $clog2(DEPTH_WORDS);

`ifdef MEM_RESPONDER_RANGE_CHK_EN
   localparam bit RANGE_CHK = 1'b1;
`else
   localparam bit RANGE_CHK = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                      state_q, state_d;
   logic                        req_ready_q, req_ready_d;
   logic                        rsp_valid_q, rsp_valid_d;
   logic                        rsp_err_q, rsp_err_d;
   logic [DW-1:0]               rsp_rdata_q, rsp_rdata_d;
   logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
   logic [DATA_WIDTH_BYTES-1:0] wen_q, wen_d;
   logic [DW-1:0]               wdata_q, wdata_d;

   // Storage is deliberately not reset; its contents are undefined at power-up.
   logic [DW-1:0] mem [DEPTH_WORDS];

   logic [IDXW-1:0] idx_w;
   logic            misalign_w;
   logic            oob_w;
   logic            err_w;

   // The low IDXW bits of the word address select the storage word; any set
   // bit above them means the index is beyond the array.
   assign idx_w      = addr_q[LSB +: IDXW];
   assign misalign_w = |addr_q[LSB-1:0];
   assign oob_w      = |addr_q[ADDR_WIDTH-1:LSB+IDXW];
   assign err_w      = misalign_w | (RANGE_CHK & oob_w);

   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      addr_d      = addr_q;
      wen_d       = wen_q;
      wdata_d     = wdata_q;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               addr_d      = req_addr;
               wen_d       = req_wenableL;
               wdata_d     = req_wdata;
               req_ready_d = 1'b0;
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            // Read data is sampled from the pre-write word in the same edge
            // that commits the lane writes.
            rsp_rdata_d = err_w ? '0 : mem[idx_w];
            rsp_err_d   = err_w;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            req_ready_d = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstL) begin
      if (!rstL) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         addr_q      <= '0;
         wen_q       <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         addr_q      <= addr_d;
         wen_q       <= wen_d;
         wdata_q     <= wdata_d;
      end
   end

   // Asynchronous reset forces state_q to IDLE at once, so a request caught
   // in ACCESS when reset asserts never reaches this write.
   always_ff @(posedge clk) begin
      if (state_q == ACCESS && !err_w) begin
         for (int i = 0; i < DATA_WIDTH_BYTES; i++) begin
            if (!wen_q[i]) begin
               mem[idx_w][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder that serves core load/store requests over a valid/ready request channel and a valid/ready response channel.
- Owns a word-organised byte-lane storage array.
- Sits between the processor top level and backing RAM.
- Serves one outstanding request at a time, with registered read data, per-byte active-low write enables and misalignment error reporting.

Parameters:
- ADDR_WIDTH, 16, byte address width.
- DATA_WIDTH_BYTES, 4, bytes per word (power of 2, ≥2).
- DEPTH_WORDS, 1024, storage depth in words (power of 2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rstL  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wenableL  in  DATA_WIDTH_BYTES  per-lane write enable, active-low; all ones means a pure read.
- req_wdata  in  8*DATA_WIDTH_BYTES  write data; lane i = bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  8*DATA_WIDTH_BYTES  word contents before any write in this request.
- rsp_err  out  1  request rejected; no storage change.

Behaviour:
- Interface: one clock `clk`; reset `rstL` is asynchronous and active-low.
- Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, captured request regs=0. Storage is not cleared; contents are undefined after power-up.
- Reset mid-operation: return to IDLE immediately. A captured request whose ACCESS edge has not occurred never writes storage.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready at edge N, capture addr/wenableL/wdata; next state ACCESS. Inputs may change freely after capture.
- ACCESS: req_ready=0. At edge N+1:
  - rsp_rdata <= storage[word].
  - For each lane i with wenableL[i]==0, storage[word][i] <= wdata lane i.
  - Next state RESP.
- RESP: rsp_valid=1, req_ready=0. rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready. On handshake, next state IDLE; rsp_valid drops the following cycle.
- Latency: rsp_valid is first high in cycle N+2. Minimum period is 3 cycles per request when rsp_ready is held high.
- Read-before-write: rsp_rdata always returns the pre-write word. A write immediately followed by a read of the same word returns the new data.
- Word index: req_addr[ADDR_WIDTH-1:log2(DATA_WIDTH_BYTES)].
- Misaligned address (low log2(DATA_WIDTH_BYTES) bits ≠0): rsp_err=1, rsp_rdata=0, no lane written, same latency.
- Index ≥ DEPTH_WORDS: handled per the optional feature below.
- rsp_valid is never asserted in IDLE or ACCESS. req_valid arriving during ACCESS/RESP is ignored until the responder returns to IDLE and req_ready is high.

Optional Feature:
- Macro: MEM_RESPONDER_RANGE_CHK_EN.
- Defined: word index ≥ DEPTH_WORDS gives rsp_err=1, rsp_rdata=0, no write.
- Undefined: index is taken modulo DEPTH_WORDS (aliasing) and the access proceeds normally. rsp_err reflects only misalignment.

Test Plan:
- Reset release, then write 0xDEADBEEF to addr 0x0010 with wenableL=4'b0000 → rsp in cycle N+2, rsp_rdata=old word, rsp_err=0. Read 0x0010 → rsp_rdata=0xDEADBEEF.
- Byte-lane write 0x000000AA with wenableL=4'b1110 to 0x0010 → subsequent read returns 0xDEADBEAA. Write with wenableL=4'b0111, wdata=0x11000000 → read returns 0x11ADBEAA.
- Misaligned read at 0x0013 → rsp_err=1, rsp_rdata=0. Following read of 0x0010 is unchanged (0x11ADBEAA).
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP while driving req_valid=1 → rsp_valid/rsp_rdata stable, req_ready=0, no second capture. Raise rsp_ready → handshake, IDLE next cycle, new request accepted.
- Assert rstL=0 during ACCESS of a write to 0x0020 (prior contents 0x12345678) → outputs reset asynchronously, rsp_valid=0. After release, read 0x0020 → 0x12345678.
- Address 0x1000 (index 1024) with DEPTH_WORDS=1024 → with MEM_RESPONDER_RANGE_CHK_EN: rsp_err=1. Without it: aliases word 0, so a write there is read back at addr 0x0000.
